// File: rtl/lcdi_window_gen_pkg.sv
// Shared types for the LCDI window generator: pixel width, phase codes, FSM states, tap bundle.
package lcdi_window_gen_pkg;

  localparam int DATA_WIDTH = 8;
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

  // LCDI_STATE0 is the idle code; a live window walks STATE6, STATE1, STATE2, STATE3.
  typedef enum logic [2:0] {
    LCDI_STATE0 = 3'd0,
    LCDI_STATE1 = 3'd1,
    LCDI_STATE2 = 3'd2,
    LCDI_STATE3 = 3'd3,
    LCDI_STATE4 = 3'd4,
    LCDI_STATE5 = 3'd5,
    LCDI_STATE6 = 3'd6
  } lcdi_state_t;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_EMIT,
    FSM_FLUSH
  } fsm_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] centre;
    logic [DATA_WIDTH-1:0] right;
  } taps_t;

  function automatic lcdi_state_t phase_code(input logic [1:0] phase);
    case (phase)
      2'd0:    return LCDI_STATE6;
      2'd1:    return LCDI_STATE1;
      2'd2:    return LCDI_STATE2;
      default: return LCDI_STATE3;
    endcase
  endfunction

endpackage

// File: rtl/lcdi_tap_delay.sv
// DATA_LAG-deep register pipe for the three window taps; advances every cycle, no backpressure.
module lcdi_tap_delay
  import lcdi_window_gen_pkg::*;
#(
  parameter int DATA_LAG = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  taps_t taps,
  output taps_t taps_lag
);

  taps_t pipe [DATA_LAG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_LAG; i++) begin
        pipe[i] <= '{left: DATA_ZERO, centre: DATA_ZERO, right: DATA_ZERO};
      end
    end else begin
      pipe[0] <= taps;
      for (int i = 1; i < DATA_LAG; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign taps_lag = pipe[DATA_LAG-1];

endmodule

// File: rtl/lcdi_window_gen.sv
// 3-tap horizontal window former driving the 4-phase LCDI sequence; taps lag state/index by DATA_LAG.
// One accept per 4-cycle window; pix_ready only when idle or on the last phase with no flush pending.
module lcdi_window_gen
  import lcdi_window_gen_pkg::*;
#(
  parameter int LINE_W   = 64,
  parameter int DATA_LAG = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [2:0]            LCDI_state,
  output logic                  state_valid,
  output logic [6:0]            index0,
  output logic [6:0]            index1,
  output logic [6:0]            index2,
  output logic [6:0]            index3,
  output logic [DATA_WIDTH-1:0] data0_out,
  output logic [DATA_WIDTH-1:0] data1_out,
  output logic [DATA_WIDTH-1:0] data2_out
);

  localparam int CW = (LINE_W > 32) ? $clog2(LINE_W) : 5;
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_W - 1);
  localparam logic [CW-1:0] PEN_COL  = CW'(LINE_W - 2);

  fsm_t          state, state_nxt;
  logic [1:0]    phase, phase_nxt;
  logic [CW-1:0] col;
  logic [CW-1:0] win_col;
  taps_t         win;
  taps_t         taps_lag;
  logic          accept;
  logic          flush_pend;
  logic          start_flush;

  // The window for LINE_W-2 is only ever emitted right after the last pixel of a line arrived.
  assign flush_pend  = (state == FSM_EMIT) && (win_col == PEN_COL);
  assign pix_ready   = (state == FSM_IDLE) || ((state == FSM_EMIT) && (phase == 2'd3) && !flush_pend);
  assign accept      = pix_valid && pix_ready;
  assign start_flush = flush_pend && (phase == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FSM_IDLE;
      phase <= 2'd0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    state_valid = 1'b0;
    LCDI_state  = LCDI_STATE0;
    index0      = '0;
    index1      = '0;
    index2      = '0;
    index3      = '0;

    case (state)
      FSM_IDLE: begin
        if (accept && (col != '0)) begin
          state_nxt = FSM_EMIT;
          phase_nxt = 2'd0;
        end
      end
      FSM_EMIT: begin
        if (phase != 2'd3) begin
          phase_nxt = phase + 2'd1;
        end else if (flush_pend) begin
          state_nxt = FSM_FLUSH;
          phase_nxt = 2'd0;
        end else if (accept && (col != '0)) begin
          state_nxt = FSM_EMIT;
          phase_nxt = 2'd0;
        end else begin
          state_nxt = FSM_IDLE;
          phase_nxt = 2'd0;
        end
      end
      FSM_FLUSH: begin
        if (phase != 2'd3) begin
          phase_nxt = phase + 2'd1;
        end else begin
          state_nxt = FSM_IDLE;
          phase_nxt = 2'd0;
        end
      end
      default: begin
        state_nxt = FSM_IDLE;
        phase_nxt = 2'd0;
      end
    endcase

    if (state != FSM_IDLE) begin
      state_valid = 1'b1;
      LCDI_state  = phase_code(phase);
      index0      = {win_col[4:0], 2'd0};
      index1      = {win_col[4:0], 2'd1};
      index2      = {win_col[4:0], 2'd2};
      index3      = {win_col[4:0], 2'd3};
    end
  end

  // Column 0 seeds all three taps so the first window comes out left-replicated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col     <= '0;
      win_col <= '0;
      win     <= '{left: DATA_ZERO, centre: DATA_ZERO, right: DATA_ZERO};
    end else if (accept) begin
      col <= (col == LAST_COL) ? '0 : col + 1'b1;
      if (col == '0) begin
        win <= '{left: pix_in, centre: pix_in, right: pix_in};
      end else begin
        win     <= '{left: win.centre, centre: win.right, right: pix_in};
        win_col <= col - 1'b1;
      end
    end else if (start_flush) begin
      win     <= '{left: win.centre, centre: win.right, right: win.right};
      win_col <= LAST_COL;
    end
  end

  lcdi_tap_delay #(
    .DATA_LAG (DATA_LAG)
  ) u_tap_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .taps     (win),
    .taps_lag (taps_lag)
  );

  assign data0_out = taps_lag.left;
  assign data1_out = taps_lag.centre;
  assign data2_out = taps_lag.right;

endmodule
